spram_bus32_32k: RTL and testbench



---
 rtl/spram_bus32_32k_if.sv | 30 +++
 rtl/spram_bus32_32k.sv | 79 +++++++
 tb/tb_spram_bus32_32k.sv | 110 +++++++++++
 3 files changed

// File: rtl/spram_bus32_32k_if.sv
// CPU bus bundle for the main memory slave: word address, write strobe,
// byte-lane mask, write data and registered read data.
interface spram_bus32_32k_if #(
  parameter int ASZ = 15,
  parameter int DSZ = 32
);
  logic [ASZ-1:0]   ai;
  logic             we;
  logic [DSZ/8-1:0] bmsk;
  logic [DSZ-1:0]   vi;
  logic [DSZ-1:0]   vo;

  // CPU side drives the request and samples read data
  modport master (
    output ai,
    output we,
    output bmsk,
    output vi,
    input  vo
  );

  // memory side samples the request and returns read data
  modport slave (
    input  ai,
    input  we,
    input  bmsk,
    input  vi,
    output vo
  );
endinterface

// File: rtl/spram_bus32_32k.sv
// 32K x 32 single-port synchronous RAM built from two 16K-word banks.
// The address MSB picks the bank; the remaining bits index within it.
// Reads are registered (one cycle latency), writes are byte-masked, and
// vo holds its last read value through write cycles.
module spram_bus32_32k #(
  parameter int ASZ = 15,
  parameter int DSZ = 32
) (
  input  logic            clk,
  input  logic            rst,
  spram_bus32_32k_if.slave bus
);

  localparam int BSZ   = ASZ - 1;
  localparam int DEPTH = 2 ** BSZ;
  localparam int NLANE = DSZ / 8;

  logic [DSZ-1:0] bank0 [DEPTH];
  logic [DSZ-1:0] bank1 [DEPTH];

  logic [BSZ-1:0] idx;
  logic           bank_hi;
  logic           wr_en;
  logic           rd_en;

  logic [DSZ-1:0] rd0_q;
  logic [DSZ-1:0] rd1_q;
  logic           sel_q;

  // request decode; reset suppresses both reads and writes
  always_comb begin
    idx     = bus.ai[BSZ-1:0];
    bank_hi = bus.ai[ASZ-1];
    wr_en   = !rst && bus.we;
    rd_en   = !rst && !bus.we;
  end

  // bank 0 byte-masked write port (array is never reset)
  always_ff @(posedge clk) begin
    if (wr_en && !bank_hi) begin
      for (int k = 0; k < NLANE; k++) begin
        if (bus.bmsk[k]) bank0[idx][8*k +: 8] <= bus.vi[8*k +: 8];
      end
    end
  end

  // bank 1 byte-masked write port (array is never reset)
  always_ff @(posedge clk) begin
    if (wr_en && bank_hi) begin
      for (int k = 0; k < NLANE; k++) begin
        if (bus.bmsk[k]) bank1[idx][8*k +: 8] <= bus.vi[8*k +: 8];
      end
    end
  end

  // bank 0 read register; only loads when this bank is read
  always_ff @(posedge clk) begin
    if (rst)                   rd0_q <= '0;
    else if (rd_en && !bank_hi) rd0_q <= bank0[idx];
  end

  // bank 1 read register; only loads when this bank is read
  always_ff @(posedge clk) begin
    if (rst)                  rd1_q <= '0;
    else if (rd_en && bank_hi) rd1_q <= bank1[idx];
  end

  // output mux select captured with the read so later ai changes don't leak through
  always_ff @(posedge clk) begin
    if (rst)        sel_q <= 1'b0;
    else if (rd_en) sel_q <= bank_hi;
  end

  // registered read data; both read registers clear on reset so vo reads 0
  always_comb begin
    bus.vo = sel_q ? rd1_q : rd0_q;
  end

endmodule

// File: tb/tb_spram_bus32_32k.sv
// Directed bench for spram_bus32_32k with a reference memory model and an
// expected-value queue checked one cycle after each request.
module tb_spram_bus32_32k;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spram_bus32_32k_if #(.ASZ(15), .DSZ(32)) bus ();

  spram_bus32_32k #(.ASZ(15), .DSZ(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] model [int];
  logic [31:0] exp_q [$];
  logic [31:0] last_vo = 32'h0;
  int checks = 0;
  int errors = 0;

  // one bus cycle: predict, drive, clock, then compare vo against the prediction
  task automatic step(input string tag, input logic w, input logic [14:0] a,
                      input logic [3:0] m, input logic [31:0] d, input logic r = 1'b0);
    logic [31:0] exp_v;
    logic [31:0] cur;
    if (r)       exp_v = 32'h0;
    else if (!w) exp_v = model.exists(int'(a)) ? model[int'(a)] : 32'hx;
    else         exp_v = last_vo;
    exp_q.push_back(exp_v);
    rst      = r;
    bus.we   = w;
    bus.ai   = a;
    bus.bmsk = m;
    bus.vi   = d;
    @(posedge clk);
    #1;
    if (w && !r) begin
      cur = model.exists(int'(a)) ? model[int'(a)] : 32'hx;
      for (int k = 0; k < 4; k++) if (m[k]) cur[8*k +: 8] = d[8*k +: 8];
      model[int'(a)] = cur;
    end
    exp_v = exp_q.pop_front();
    checks++;
    assert (bus.vo === exp_v) else begin
      errors++;
      $error("FAIL %s addr=%h vo=%h expected=%h", tag, a, bus.vo, exp_v);
    end
    last_vo = exp_v;
  endtask

  initial begin
    bus.we = 1'b0; bus.ai = '0; bus.bmsk = '0; bus.vi = '0;
    @(posedge clk); #1;

    // reset state
    step("reset_vo", 1'b0, 15'h0, 4'h0, 32'h0, 1'b1);
    step("reset_vo2", 1'b1, 15'h1, 4'hF, 32'hDEAD_BEEF, 1'b1);

    // walking bit, low memory
    for (int i = 0; i < 15; i++)
      step("walk_wr", 1'b1, 15'(i), 4'hF, (32'h1 << i) | 32'(i & 3));
    for (int i = 0; i < 15; i++)
      step("walk_rd", 1'b0, 15'(i), 4'h0, 32'h0);

    // bank range and aliasing
    step("bank_wr1", 1'b1, 15'h401F, 4'hF, 32'hFFFF_C002);
    step("bank_wr0", 1'b1, 15'h0020, 4'hF, 32'h0000_0001);
    step("bank_wr2", 1'b1, 15'h001F, 4'hF, 32'h5A5A_0F0F);
    step("bank_rd1", 1'b0, 15'h401F, 4'h0, 32'h0);
    step("bank_wrh", 1'b1, 15'h001F, 4'hF, 32'h1111_2222);
    step("bank_rd0", 1'b0, 15'h0020, 4'h0, 32'h0);
    step("bank_rd2", 1'b0, 15'h001F, 4'h0, 32'h0);
    step("bank_rd1b", 1'b0, 15'h401F, 4'h0, 32'h0);

    // top of memory walking pattern
    for (int j = 0; j < 15; j++)
      step("top_wr", 1'b1, 15'(32'h7FFF - j), 4'hF, (32'h1 << j) | 32'(j & 3));
    for (int j = 0; j < 15; j++)
      step("top_rd", 1'b0, 15'(32'h7FFF - j), 4'h0, 32'h0);

    // byte mask
    step("bm_init", 1'b1, 15'h0010, 4'hF, 32'h1234_5678);
    step("bm_0111", 1'b1, 15'h0010, 4'h7, 32'h8000_0001);
    step("bm_rd1", 1'b0, 15'h0010, 4'h0, 32'h0);
    step("bm_0011", 1'b1, 15'h0010, 4'h3, 32'hAAAA_AAAA);
    step("bm_rd2", 1'b0, 15'h0010, 4'h0, 32'h0);
    step("bm_0000", 1'b1, 15'h0010, 4'h0, 32'hFFFF_FFFF);
    step("bm_rd3", 1'b0, 15'h0010, 4'h0, 32'h0);

    // pipelined reads, then a write holding vo
    step("pipe_5", 1'b0, 15'h0005, 4'h0, 32'h0);
    step("pipe_6", 1'b0, 15'h0006, 4'h0, 32'h0);
    step("pipe_7", 1'b0, 15'h0007, 4'h0, 32'h0);
    step("pipe_hold", 1'b1, 15'h4007, 4'hF, 32'hCAFE_F00D);
    step("pipe_rdhi", 1'b0, 15'h4007, 4'h0, 32'h0);

    // reset mid-sequence suppresses the write and clears vo
    step("rst_pre", 1'b0, 15'h0003, 4'h0, 32'h0);
    step("rst_wr", 1'b1, 15'h0003, 4'hF, 32'h0BAD_0BAD, 1'b1);
    step("rst_rd", 1'b0, 15'h0003, 4'h0, 32'h0);
    step("rst_rd0", 1'b0, 15'h0000, 4'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
